// File: rtl/spi_flash_writer.sv
`timescale 1ns/1ps
// SPI mode-3 master that programs one flash page (optional 4KB sector erase first) from a 32-bit word stream.
// Two clk per SPI bit; o_wready pulses once per word and an empty stream parks SCK high with CSS low.
module spi_flash_writer #(
   parameter int          PAGE_WORDS = 64,
   parameter int          CS_GAP     = 8,
   parameter logic [19:0] POLL_LIMIT = 20'd65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_erase,
   input  logic [23:0] i_addr,
   input  logic        i_wvalid,
   output logic        o_wready,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic        SPI_CSS,
   output logic        SPI_CLK,
   output logic        SPI_MOSI,
   input  logic        SPI_MISO
);

   typedef enum logic [2:0] {IDLE, WREN, SE, PP, DATA, RDSR, GAP, DONE} state_t;

   localparam logic [6:0] LAST_WORD = 7'(PAGE_WORDS);
   localparam logic [3:0] GAP_LOAD  = 4'(CS_GAP - 1);

   state_t      state;
   state_t      nxt_state;
   logic [31:0] sh;
   logic [31:0] nxt_sh;
   logic [31:0] word_swap;
   logic [4:0]  bit_cnt;
   logic [4:0]  nxt_cnt;
   logic [6:0]  word_cnt;
   logic [19:0] poll_cnt;
   logic [3:0]  gap_cnt;
   logic [2:0]  step;
   logic        in_b;
   logic [15:0] addr_q;
   logic        unused_ok;

   // Low address bits are dropped by design; sh[31] is only ever consumed from nxt_sh at load.
   assign unused_ok = ^{i_addr[7:0], sh[31]};
   assign word_swap = {i_wdata[7:0], i_wdata[15:8], i_wdata[23:16], i_wdata[31:24]};

   // Step list: 0 WREN, 1 SE, 2 RDSR, 3 WREN, 4 PP, 5 RDSR, 6 DONE.
   always_comb begin
      nxt_state = WREN;
      nxt_sh    = {8'h06, 24'hFFFFFF};
      nxt_cnt   = 5'd7;
      case (step)
         3'd1: begin
            nxt_state = SE;
            nxt_sh    = {8'h20, addr_q[15:4], 12'h000};
            nxt_cnt   = 5'd31;
         end
         3'd2, 3'd5: begin
            nxt_state = RDSR;
            nxt_sh    = {8'h05, 24'hFFFFFF};
            nxt_cnt   = 5'd15;
         end
         3'd4: begin
            nxt_state = PP;
            nxt_sh    = {8'h02, addr_q, 8'h00};
            nxt_cnt   = 5'd31;
         end
         3'd6: nxt_state = DONE;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         SPI_CSS  <= 1'b1;
         SPI_CLK  <= 1'b1;
         SPI_MOSI <= 1'b1;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         o_error  <= 1'b0;
         o_wready <= 1'b0;
         sh       <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
         poll_cnt <= '0;
         gap_cnt  <= '0;
         step     <= '0;
         in_b     <= 1'b0;
         addr_q   <= '0;
      end else begin
         o_done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (i_start) begin
                  addr_q   <= i_addr[23:8];
                  step     <= i_erase ? 3'd0 : 3'd3;
                  o_busy   <= 1'b1;
                  o_error  <= 1'b0;
                  word_cnt <= '0;
                  poll_cnt <= '0;
                  gap_cnt  <= '0;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (nxt_state == DONE) begin
                  state  <= DONE;
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
               end else begin
                  state    <= nxt_state;
                  sh       <= nxt_sh;
                  bit_cnt  <= nxt_cnt;
                  SPI_CSS  <= 1'b0;
                  SPI_CLK  <= 1'b0;
                  SPI_MOSI <= nxt_sh[31];
                  in_b     <= 1'b0;
               end
            end
            WREN, SE, PP, DATA, RDSR: begin
               if (!in_b) begin
                  SPI_CLK <= 1'b1;
                  in_b    <= 1'b1;
                  // Request the next word during the last bit's high phase so words stream back to back.
                  if (bit_cnt == 5'd0 && (state == PP || (state == DATA && word_cnt != LAST_WORD)))
                     o_wready <= 1'b1;
               end else if (bit_cnt != 5'd0) begin
                  bit_cnt  <= bit_cnt - 5'd1;
                  sh       <= {sh[30:0], 1'b1};
                  SPI_MOSI <= sh[30];
                  SPI_CLK  <= 1'b0;
                  in_b     <= 1'b0;
               end else if (o_wready) begin
                  if (i_wvalid) begin
                     sh       <= word_swap;
                     bit_cnt  <= 5'd31;
                     SPI_MOSI <= i_wdata[7];
                     SPI_CLK  <= 1'b0;
                     in_b     <= 1'b0;
                     o_wready <= 1'b0;
                     word_cnt <= word_cnt + 7'd1;
                     state    <= DATA;
                  end
               end else if (state == RDSR && SPI_MISO) begin
                  SPI_CSS  <= 1'b1;
                  SPI_MOSI <= 1'b1;
                  if (poll_cnt == POLL_LIMIT - 20'd1) begin
                     o_error <= 1'b1;
                     o_busy  <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     poll_cnt <= poll_cnt + 20'd1;
                     gap_cnt  <= GAP_LOAD;
                     state    <= GAP;
                  end
               end else begin
                  SPI_CSS  <= 1'b1;
                  SPI_MOSI <= 1'b1;
                  poll_cnt <= '0;
                  step     <= step + 3'd1;
                  gap_cnt  <= GAP_LOAD;
                  state    <= GAP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_writer.sv
`timescale 1ns/1ps
// Directed bench for spi_flash_writer with a behavioural SPI NOR model (command log, page capture, WIP timer).
module tb_spi_flash_writer;

   logic        clk = 1'b0;
   logic        reset, i_start, i_erase, i_wvalid, SPI_MISO;
   logic [23:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_wready, o_busy, o_done, o_error, SPI_CSS, SPI_CLK, SPI_MOSI;

   always #5 clk = ~clk;

   spi_flash_writer #(.PAGE_WORDS(64), .CS_GAP(8), .POLL_LIMIT(20'd4)) dut (
      .clk(clk), .reset(reset), .i_start(i_start), .i_erase(i_erase), .i_addr(i_addr),
      .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .o_busy(o_busy),
      .o_done(o_done), .o_error(o_error), .SPI_CSS(SPI_CSS), .SPI_CLK(SPI_CLK),
      .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- flash model ----------------
   int          frames, rdsr_cnt, wip_polls, wip_left, bitn, min_gap, pp_len, sck_edges;
   bit          stuck, have_rise, wip_now;
   logic [7:0]  cur;
   logic [7:0]  fr[$];
   logic [7:0]  cmd_q[$];
   logic [23:0] se_addr, pp_addr;
   logic [7:0]  pp_data[256];
   time         rise_t;

   always @(negedge SPI_CSS) begin
      bitn = 0;
      fr.delete();
      wip_now = stuck || (wip_left > 0);
      if (have_rise && int'(($time - rise_t) / 10) < min_gap) min_gap = int'(($time - rise_t) / 10);
   end

   always @(posedge SPI_CLK) begin
      sck_edges++;
      if (SPI_CSS === 1'b0) begin
         cur = {cur[6:0], SPI_MOSI};
         bitn++;
         if (bitn % 8 == 0) fr.push_back(cur);
      end
   end

   always @(negedge SPI_CLK)
      if (SPI_CSS === 1'b0)
         SPI_MISO = (bitn == 15 && fr.size() > 0 && fr[0] == 8'h05) ? wip_now : 1'b0;

   always @(posedge SPI_CSS) begin
      if (fr.size() > 0) begin
         frames++;
         cmd_q.push_back(fr[0]);
         case (fr[0])
            8'h20: begin
               if (fr.size() >= 4) se_addr = {fr[1], fr[2], fr[3]};
               wip_left = wip_polls;
            end
            8'h02: begin
               if (fr.size() >= 4) pp_addr = {fr[1], fr[2], fr[3]};
               pp_len = (fr.size() >= 4) ? fr.size() - 4 : 0;
               for (int k = 0; k < pp_len && k < 256; k++) pp_data[k] = fr[k + 4];
               wip_left = wip_polls;
            end
            8'h05: begin
               rdsr_cnt++;
               if (wip_left > 0) wip_left--;
            end
            default: ;
         endcase
      end
      fr.delete();
      bitn = 0;
      rise_t = $time;
      have_rise = 1'b1;
   end

   task automatic clear_model(input int polls, input bit stk);
      frames = 0; rdsr_cnt = 0; wip_left = 0; pp_len = 0; min_gap = 1000;
      se_addr = '0; pp_addr = '0; have_rise = 1'b0;
      wip_polls = polls; stuck = stk;
      cmd_q.delete();
      for (int k = 0; k < 256; k++) pp_data[k] = 8'hEE;
   endtask

   task automatic check_page(input string tag);
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (pp_data[k] !== 8'(k)) bad++;
      check({tag, "_len"}, pp_len, 256);
      check({tag, "_bytes_bad"}, bad, 0);
   endtask

   // ---------------- stimulus driver ----------------
   int done_cnt, words_fed, hold_bad;
   bit timed_out;

   task automatic run_seq(input logic erase, input logic [23:0] addr,
                          input int stall_word, input int reset_word, input int poke);
      int  widx, stall;
      logic fire;
      widx = 0; stall = 0; done_cnt = 0; hold_bad = 0; timed_out = 1'b1;
      @(negedge clk);
      i_erase = erase; i_addr = addr; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         if (o_done) done_cnt++;
         if (!o_busy) begin timed_out = 1'b0; break; end
         if (widx == reset_word) begin reset = 1'b1; i_wvalid = 1'b0; timed_out = 1'b0; break; end
         i_start = (cyc == poke);
         if (cyc == poke) begin i_addr = 24'hABCDEF; i_erase = ~erase; end
         if (widx == stall_word && stall < 20) begin
            i_wvalid = 1'b0;
            if (o_wready) stall++;
         end else begin
            i_wvalid = (widx < 64);
         end
         i_wdata = 32'h03020100 + widx * 32'h04040404;
         if (o_wready && !i_wvalid && (SPI_CLK !== 1'b1 || SPI_CSS !== 1'b0)) hold_bad++;
         fire = i_wvalid && o_wready;
         @(negedge clk);
         if (fire) widx++;
      end
      i_start = 1'b0; i_wvalid = 1'b0;
      words_fed = widx;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int edges0;
      reset = 1'b1; i_start = 1'b0; i_erase = 1'b0; i_addr = '0;
      i_wvalid = 1'b0; i_wdata = '0; SPI_MISO = 1'b0; sck_edges = 0; cur = '0;
      clear_model(0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_css", SPI_CSS, 1);
      check("rst_sck", SPI_CLK, 1);
      check("rst_mosi", SPI_MOSI, 1);
      check("rst_flags", {o_busy, o_done, o_error, o_wready}, 4'b0000);
      @(negedge clk);
      reset = 1'b0;

      // 1: plain page program, one busy poll
      clear_model(1, 1'b0);
      run_seq(1'b0, 24'h020000, -1, -1, -1);
      check("c1_timeout", timed_out, 0);
      check("c1_done", done_cnt, 1);
      check("c1_words", words_fed, 64);
      check("c1_frames", frames, 4);
      check("c1_cmd0", cmd_q[0], 8'h06);
      check("c1_cmd1", cmd_q[1], 8'h02);
      check("c1_cmd2", cmd_q[2], 8'h05);
      check("c1_pp_addr", pp_addr, 24'h020000);
      check("c1_rdsr", rdsr_cnt, 2);
      check("c1_gap", min_gap, 8);
      check("c1_error", o_error, 0);
      check_page("c1_page");

      // 2: erase then program, three busy polls per wait
      clear_model(3, 1'b0);
      run_seq(1'b1, 24'h021234, -1, -1, -1);
      check("c2_timeout", timed_out, 0);
      check("c2_done", done_cnt, 1);
      check("c2_frames", frames, 12);
      check("c2_cmd1", cmd_q[1], 8'h20);
      check("c2_cmd5", cmd_q[5], 8'h05);
      check("c2_cmd6", cmd_q[6], 8'h06);
      check("c2_cmd7", cmd_q[7], 8'h02);
      check("c2_se_addr", se_addr, 24'h021000);
      check("c2_pp_addr", pp_addr, 24'h021200);
      check("c2_rdsr", rdsr_cnt, 8);
      check_page("c2_page");

      // 3: 20-cycle underrun at word 10
      clear_model(0, 1'b0);
      run_seq(1'b0, 24'h020000, 10, -1, -1);
      check("c3_timeout", timed_out, 0);
      check("c3_hold_bad", hold_bad, 0);
      check("c3_done", done_cnt, 1);
      check("c3_frames", frames, 3);
      check_page("c3_page");

      // 4: WIP stuck high, poll limit 4
      clear_model(0, 1'b1);
      run_seq(1'b0, 24'h020000, -1, -1, -1);
      check("c4_timeout", timed_out, 0);
      check("c4_done", done_cnt, 0);
      check("c4_error", o_error, 1);
      check("c4_busy", o_busy, 0);
      check("c4_rdsr", rdsr_cnt, 4);
      check("c4_frames", frames, 6);

      // 6: start pulse while busy is ignored; accepted start clears error
      clear_model(0, 1'b0);
      run_seq(1'b0, 24'h0303A5, -1, -1, 200);
      check("c6_timeout", timed_out, 0);
      check("c6_error", o_error, 0);
      check("c6_done", done_cnt, 1);
      check("c6_frames", frames, 3);
      check("c6_pp_addr", pp_addr, 24'h030300);
      check("c6_cmd0", cmd_q[0], 8'h06);
      check("c6_gap", min_gap, 8);
      check_page("c6_page");

      // 5: reset in the middle of the data phase, then a clean run
      clear_model(0, 1'b0);
      run_seq(1'b0, 24'h020000, -1, 30, -1);
      check("c5_reached", timed_out, 0);
      @(posedge clk);
      #1;
      edges0 = sck_edges;
      check("c5_css", SPI_CSS, 1);
      check("c5_sck", SPI_CLK, 1);
      check("c5_busy", o_busy, 0);
      check("c5_wready", o_wready, 0);
      repeat (10) @(posedge clk);
      #1;
      check("c5_no_sck", sck_edges - edges0, 0);
      @(negedge clk);
      reset = 1'b0;
      clear_model(0, 1'b0);
      run_seq(1'b0, 24'h020000, -1, -1, -1);
      check("c5_timeout", timed_out, 0);
      check("c5_done", done_cnt, 1);
      check("c5_frames", frames, 3);
      check("c5_pp_addr", pp_addr, 24'h020000);
      check_page("c5_page");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
